// File: rtl/cam_pkg.sv
// Shared constants for the camera capture block: default geometry, FSM encoding
// and the bit positions of the sticky error flags.
package cam_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } cam_state_e;

  localparam logic [1:0] ERR_ODD   = 2'd0;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_FRAME = 2'd2;

endpackage

// File: rtl/cam_byte_pack.sv
// Pairs RGB444 camera bytes into 12-bit {B,G,R} pixels with one cycle of latency
// and flags a dangling byte left over when a line ends.
module cam_byte_pack (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_en,
  input  logic        i_href,
  input  logic        i_href_fall,
  input  logic [7:0]  i_data,
  output logic        o_pix_vld,
  output logic [11:0] o_pix_data,
  output logic        o_dangle
);

  logic        r_phase;
  logic [3:0]  r_red;
  logic        r_vld;
  logic [11:0] r_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= 1'b0;
      r_red   <= '0;
      r_vld   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_vld <= 1'b0;
      if (!i_href) begin
        r_phase <= 1'b0;
      end else if (i_en) begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_red <= i_data[3:0];
        end else begin
          r_data <= {i_data[3:0], i_data[7:4], r_red};
          r_vld  <= 1'b1;
        end
      end
    end
  end

  // phase still reflects the last byte of the line in the cycle the fall is seen
  assign o_dangle   = i_href_fall & r_phase;
  assign o_pix_vld  = r_vld;
  assign o_pix_data = r_data;

endmodule

// File: rtl/cam_capture.sv
// Camera frame capture: sync edge detection, capture FSM, frame-buffer address
// generation, line/frame accounting and sticky error flags.
module cam_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE = cam_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = cam_pkg::V_ACTIVE,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cam_vsynk,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              cap_en,
  input  logic              snap_mode,
  input  logic              snap_req,
  input  logic              clr_err,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [11:0]       pix_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic [9:0]        line_cnt,
  output logic [2:0]        err
);

  localparam int unsigned       LP_FRAME    = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LP_ADDR_MAX = ADDR_W'(LP_FRAME - 1);

  cam_state_e        r_state, w_state_nxt;
  logic              r_vs_q, r_hr_q, r_fs, r_fd, r_full;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_tot;
  logic [15:0]       r_lpix;
  logic [9:0]        r_line;
  logic [2:0]        r_err, w_err_nxt;
  logic              w_vs_fall, w_vs_rise, w_hr_rise, w_hr_fall;
  logic              w_active, w_fs, w_fe, w_pix_vld, w_pix_act, w_we, w_ovf, w_dangle;
  logic [11:0]       w_pix_data;
  logic [16:0]       w_lpix_now;
  logic [ADDR_W+1:0] w_tot_now;

  assign w_vs_fall = r_vs_q & ~cam_vsynk;
  assign w_vs_rise = ~r_vs_q & cam_vsynk;
  assign w_hr_rise = cam_href & ~r_hr_q;
  assign w_hr_fall = r_hr_q & ~cam_href;

  assign w_active  = (r_state == ST_ACTIVE) & cap_en;
  assign w_fs      = cap_en & ((r_state == ST_ARMED) | (r_state == ST_ACTIVE)) & w_vs_fall;
  assign w_fe      = w_active & w_vs_rise;
  assign w_pix_act = w_pix_vld & (r_state == ST_ACTIVE);
  assign w_we      = w_pix_act & ~r_full;
  assign w_ovf     = w_pix_act & r_full;

  // include a pixel emerging in the same cycle as the line/frame end
  assign w_lpix_now = {1'b0, r_lpix} + 17'(w_pix_act);
  assign w_tot_now  = {1'b0, r_tot} + (ADDR_W + 2)'(w_pix_act);

  cam_byte_pack u_pack (
    .clk        (clk),
    .rstn       (rstn),
    .i_en       (w_active),
    .i_href     (cam_href),
    .i_href_fall(w_hr_fall),
    .i_data     (cam_data),
    .o_pix_vld  (w_pix_vld),
    .o_pix_data (w_pix_data),
    .o_dangle   (w_dangle)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (!cap_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (!snap_mode || snap_req) w_state_nxt = ST_ARMED;
        ST_ARMED:  if (w_vs_fall) w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: if (w_vs_rise) w_state_nxt = snap_mode ? ST_HOLD : ST_ARMED;
        ST_HOLD:   if (snap_req) w_state_nxt = ST_ARMED;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_err_nxt = clr_err ? '0 : r_err;
    if (w_active && w_dangle) w_err_nxt[ERR_ODD] = 1'b1;
    if (w_active && w_hr_fall && (w_lpix_now != 17'(H_ACTIVE))) w_err_nxt[ERR_LEN] = 1'b1;
    if ((w_active && (w_ovf || w_vs_fall)) ||
        (w_fe && (w_tot_now != (ADDR_W + 2)'(LP_FRAME))))
      w_err_nxt[ERR_FRAME] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_vs_q  <= 1'b0;
      r_hr_q  <= 1'b0;
      r_fs    <= 1'b0;
      r_fd    <= 1'b0;
      r_full  <= 1'b0;
      r_addr  <= '0;
      r_tot   <= '0;
      r_lpix  <= '0;
      r_line  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vs_q  <= cam_vsynk;
      r_hr_q  <= cam_href;
      r_fs    <= w_fs;
      r_fd    <= w_fe;
      r_err   <= w_err_nxt;
      if (w_fs) begin
        r_addr <= '0;
        r_full <= 1'b0;
        r_tot  <= '0;
        r_line <= '0;
      end else if (r_state == ST_ACTIVE) begin
        if (w_we) begin
          if (r_addr == LP_ADDR_MAX) r_full <= 1'b1;
          else                       r_addr <= r_addr + 1'b1;
        end
        if (w_pix_act && (r_tot != '1)) r_tot <= r_tot + 1'b1;
        if (w_active && w_hr_fall && (r_line != 10'd1023)) r_line <= r_line + 1'b1;
      end
      if (w_active && w_hr_rise)              r_lpix <= '0;
      else if (w_pix_act && (r_lpix != '1))   r_lpix <= r_lpix + 1'b1;
    end
  end

  assign pix_we      = w_we;
  assign pix_addr    = r_addr;
  assign pix_data    = w_pix_data;
  assign frame_start = r_fs;
  assign frame_done  = r_fd;
  assign busy        = (r_state == ST_ARMED) | (r_state == ST_ACTIVE);
  assign line_cnt    = r_line;
  assign err         = r_err;

endmodule

// File: tb/tb_cam_capture.sv
// Randomised frame-level bench for cam_capture on a reduced 8x8 geometry,
// checked against a per-frame pixel/error model built from the raw byte stream.
module tb_cam_capture;

  localparam int H     = 8;
  localparam int V     = 8;
  localparam int AW    = 8;
  localparam int FRAME = H * V;

  logic          clk = 1'b0;
  logic          rstn, cam_vsynk, cam_href, cap_en, snap_mode, snap_req, clr_err;
  logic [7:0]    cam_data;
  logic          pix_we, frame_start, frame_done, busy;
  logic [AW-1:0] pix_addr;
  logic [11:0]   pix_data;
  logic [9:0]    line_cnt;
  logic [2:0]    err;

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .cam_vsynk(cam_vsynk), .cam_href(cam_href),
    .cam_data(cam_data), .cap_en(cap_en), .snap_mode(snap_mode),
    .snap_req(snap_req), .clr_err(clr_err), .pix_we(pix_we),
    .pix_addr(pix_addr), .pix_data(pix_data), .frame_start(frame_start),
    .frame_done(frame_done), .busy(busy), .line_cnt(line_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [AW+11:0] obs_q[$];
  int             n_done, n_start;

  always @(negedge clk) begin
    if (pix_we)      obs_q.push_back({pix_addr, pix_data});
    if (frame_done)  n_done++;
    if (frame_start) n_start++;
  end

  task automatic clear_obs();
    obs_q.delete();
    n_done  = 0;
    n_start = 0;
  endtask

  int             ll[$];
  logic [7:0]     fb[$];
  logic [AW+11:0] exp_q[$];
  logic [2:0]     exp_err;
  bit             g_pair, pair_due;

  task automatic model_frame();
    int pos   = 0;
    int total = 0;
    logic [7:0] b0, b1;
    exp_q.delete();
    exp_err = '0;
    foreach (ll[i]) begin
      if (ll[i] % 2 != 0) exp_err[0] = 1'b1;
      if (ll[i] / 2 != H) exp_err[1] = 1'b1;
      for (int p = 0; p < ll[i] / 2; p++) begin
        b0 = fb[pos + 2*p];
        b1 = fb[pos + 2*p + 1];
        if (total < FRAME) exp_q.push_back({AW'(total), b1[3:0], b1[7:4], b0[3:0]});
        else               exp_err[2] = 1'b1;
        total++;
      end
      pos += ll[i];
    end
    if (total != FRAME) exp_err[2] = 1'b1;
  endtask

  task automatic build_frame(input int nlines, input int bad_line, input bit pair);
    ll.delete();
    fb.delete();
    for (int i = 0; i < nlines; i++) begin
      int n;
      n = (i == bad_line) ? 2*H - 1 : 2*H;
      ll.push_back(n);
      for (int j = 0; j < n; j++) fb.push_back(8'($urandom));
    end
    g_pair = pair;
    if (pair) begin
      fb[0] = 8'h0A;
      fb[1] = 8'h5C;
    end
    model_frame();
  endtask

  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge clk);
    #1;
    if (pair_due) begin
      chk("pair_we", pix_we, 1);
      chk("pair_data", pix_data, 12'hC5A);
      chk("pair_addr", pix_addr, 0);
      pair_due = 0;
    end
    cam_vsynk = vs;
    cam_href  = hr;
    cam_data  = d;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_we"}, pix_we, 0);
    chk({nm, "_addr"}, pix_addr, 0);
    chk({nm, "_data"}, pix_data, 0);
    chk({nm, "_fstart"}, frame_start, 0);
    chk({nm, "_fdone"}, frame_done, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_lines"}, line_cnt, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  task automatic drive_frame(input int abort_addr, input int rst_line, input int bad_line);
    int pos       = 0;
    bit abort_chk = 0;
    bit aborted   = 0;
    repeat (3) step(1'b1, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    foreach (ll[i]) begin
      if (i == rst_line) begin
        #2 rstn = 1'b0;
        #1 chk_reset("midrst");
        rstn = 1'b1;
        clear_obs();
      end
      for (int j = 0; j < ll[i]; j++) begin
        step(1'b0, 1'b1, fb[pos + j]);
        if (abort_chk) begin
          chk("abort_we", pix_we, 0);
          abort_chk = 0;
        end
        if (abort_addr >= 0 && !aborted && pix_we && pix_addr == AW'(abort_addr)) begin
          cap_en    = 1'b0;
          aborted   = 1;
          abort_chk = 1;
        end
        if (g_pair && i == 0 && j == 1) pair_due = 1;
      end
      pos += ll[i];
      repeat (2 + $urandom_range(0, 2)) step(1'b0, 1'b0, 8'h00);
      if (aborted) cap_en = 1'b1;
      if (i == bad_line) chk("err_line", err, 3'b011);
    end
    repeat (3) step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic check_frame(input string nm, input int n_exp, input int exp_done,
                             input logic [2:0] exp_e);
    chk({nm, "_nwr"}, obs_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < obs_q.size(); i++) chk({nm, "_wr"}, obs_q[i], exp_q[i]);
    chk({nm, "_done"}, n_done, exp_done);
    chk({nm, "_err"}, err, exp_e);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    clr_err = 1'b0;
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    snap_req = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; cam_vsynk = 1'b1; cam_href = 1'b0; cam_data = '0;
    cap_en = 1'b0; snap_mode = 1'b0; snap_req = 1'b0; clr_err = 1'b0;
    g_pair = 0; pair_due = 0;
    #12;
    chk_reset("por");
    rstn   = 1'b1;
    cap_en = 1'b1;

    // continuous capture, first frame carries the fixed 0x0A,0x5C pair
    for (int f = 0; f < 2; f++) begin
      clear_obs();
      build_frame(V, -1, f == 0);
      drive_frame(-1, -1, -1);
      check_frame("cont", FRAME, 1, 3'b000);
      chk("cont_start", n_start, 1);
      chk("cont_last", pix_addr, FRAME - 1);
      chk("cont_lines", line_cnt, V);
      chk("cont_busy", busy, 1);
    end

    // one line too many: writes stop at the last address
    clear_obs();
    build_frame(V + 1, -1, 0);
    drive_frame(-1, -1, -1);
    check_frame("ovf", FRAME, 1, exp_err);
    chk("ovf_last", pix_addr, FRAME - 1);
    chk("ovf_lines", line_cnt, V + 1);
    pulse_clr();
    chk("clr_ovf", err, 0);

    // short last line (odd byte count)
    clear_obs();
    build_frame(V, V - 1, 0);
    drive_frame(-1, -1, V - 1);
    check_frame("odd", exp_q.size(), 1, exp_err);
    pulse_clr();
    chk("clr_odd", err, 0);

    // capture disabled mid-line, then re-enabled
    clear_obs();
    build_frame(V, -1, 0);
    drive_frame(20, -1, -1);
    check_frame("abort", 21, 0, 3'b000);
    clear_obs();
    build_frame(V, -1, 0);
    drive_frame(-1, -1, -1);
    check_frame("recap", FRAME, 1, 3'b000);
    chk("recap_start", n_start, 1);

    // single-shot
    snap_mode = 1'b1;
    cap_en    = 1'b0;
    step(1'b1, 1'b0, 8'h00);
    cap_en = 1'b1;
    repeat (3) step(1'b1, 1'b0, 8'h00);
    chk("ss_idle_busy", busy, 0);
    pulse_snap();
    chk("ss_arm_busy", busy, 1);
    clear_obs();
    build_frame(V, -1, 0);
    drive_frame(-1, -1, -1);
    check_frame("ss1", FRAME, 1, 3'b000);
    chk("ss1_busy", busy, 0);
    clear_obs();
    repeat (2) begin
      build_frame(V, -1, 0);
      drive_frame(-1, -1, -1);
    end
    chk("ss_hold_nwr", obs_q.size(), 0);
    chk("ss_hold_done", n_done, 0);
    chk("ss_hold_busy", busy, 0);
    pulse_snap();
    chk("ss2_arm_busy", busy, 1);
    clear_obs();
    build_frame(V, -1, 0);
    drive_frame(-1, -1, -1);
    check_frame("ss2", FRAME, 1, 3'b000);
    chk("ss2_busy", busy, 0);

    // asynchronous reset in the middle of a frame
    snap_mode = 1'b0;
    cap_en    = 1'b0;
    step(1'b1, 1'b0, 8'h00);
    cap_en = 1'b1;
    repeat (2) step(1'b1, 1'b0, 8'h00);
    clear_obs();
    build_frame(V, -1, 0);
    drive_frame(-1, 3, -1);
    check_frame("rst", 0, 0, 3'b000);
    clear_obs();
    build_frame(V, -1, 0);
    drive_frame(-1, -1, -1);
    check_frame("postrst", FRAME, 1, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter H_ACTIVE, 640, pixels per valid line.
REQ-002 Parameter V_ACTIVE, 480, valid lines per frame.
REQ-003 Parameter ADDR_W, 19, frame-buffer address width.
REQ-004 Port clk  in  1  camera pixel clock; the only clock in the block.
REQ-005 Port rstn  in  1  reset, asynchronous, active-low.
REQ-006 Port cam_vsynk  in  1  camera VSYNC; high = vertical blanking.
REQ-007 Port cam_href  in  1  camera HREF; high = valid line bytes.
REQ-008 Port cam_data  in  8  camera byte bus, RGB444 two bytes per pixel.
REQ-009 Port cap_en  in  1  capture enable level.
REQ-010 Port snap_mode  in  1  0 = continuous capture, 1 = single-shot capture.
REQ-011 Port snap_req  in  1  one-cycle pulse that arms a single-shot capture.
REQ-012 Port clr_err  in  1  one-cycle pulse that clears the sticky error flags.
REQ-013 Port pix_we  out  1  frame-buffer write strobe.
REQ-014 Port pix_addr  out  ADDR_W  linear write address.
REQ-015 Port pix_data  out  12  packed pixel {B,G,R}.
REQ-016 Port frame_start  out  1  one-cycle pulse when a frame begins.
REQ-017 Port frame_done  out  1  one-cycle pulse when a frame ends.
REQ-018 Port busy  out  1  high in states ARMED and ACTIVE.
REQ-019 Port line_cnt  out  10  number of completed lines in the current frame.
REQ-020 Port err  out  3  sticky error flags: [0] odd byte count in a line, [1] line length not equal to H_ACTIVE, [2] frame pixel count not equal to H_ACTIVE*V_ACTIVE or address overflow.

Function
REQ-021 cam_vsynk and cam_href shall be registered once; edge detection shall compare the current input with its registered copy.
REQ-022 Frame-start event: falling edge of cam_vsynk. Frame-end event: rising edge of cam_vsynk.
REQ-023 FSM states and transitions:
- IDLE -> ARMED when cap_en=1 and (snap_mode=0 or snap_req=1).
- ARMED -> ACTIVE on frame-start; frame_start pulses in the same cycle.
- ACTIVE -> ARMED on frame-end when snap_mode=0.
- ACTIVE -> HOLD on frame-end when snap_mode=1.
- HOLD -> ARMED on snap_req=1 with cap_en=1.
REQ-024 cap_en=0 shall force IDLE on the next edge from any state, aborting any frame in progress; pix_we shall be 0 from that cycle on, and frame_done shall not pulse.
REQ-025 frame_done shall pulse for one cycle on every ACTIVE-state frame-end.
REQ-026 Byte phase shall clear while cam_href=0.
- In ACTIVE with cam_href=1, byte phase toggles on each clock.
- The phase-0 byte's [3:0] is held as R.
- On the phase-1 byte, pix_data = {byte1[3:0], byte1[7:4], R}.
REQ-027 pix_we shall assert for one cycle, one clock after the phase-1 byte is sampled (latency 1); pix_addr and pix_data shall be valid in that same cycle.
REQ-028 pix_addr:
- Clears to 0 on frame-start.
- Increments after each write.
- Holds at H_ACTIVE*V_ACTIVE-1 with no further writes once it is reached; a further pixel sets err[2].
REQ-029 A per-line pixel counter clears on cam_href rising edge. On cam_href falling edge:
- line_cnt increments, saturating at 1023.
- Counter not equal to H_ACTIVE sets err[1].
- Byte phase 1 (dangling byte) sets err[0], and the dangling byte is discarded.
REQ-030 On frame-end in ACTIVE, a total pixel count not equal to H_ACTIVE*V_ACTIVE shall set err[2].
REQ-031 line_cnt shall clear on frame-start.
REQ-032 In IDLE, ARMED and HOLD, pix_we shall be 0 and the counters shall hold.
REQ-033 clr_err shall clear err; an error event in the same cycle wins, and the flag stays set.
REQ-034 snap_req in ACTIVE shall be ignored; snap_req in IDLE with snap_mode=1 and cap_en=1 shall arm.
REQ-035 A frame-start seen in ACTIVE (a vsync glitch) shall restart the frame: address 0, line_cnt 0, frame_start pulses, err[2] set.

Reset
REQ-036 On rstn=0, asynchronously and regardless of clk, the following shall take these values:
- FSM state: IDLE.
- pix_we: 0.
- pix_addr: 0.
- pix_data: 0.
- frame_start: 0.
- frame_done: 0.
- busy: 0.
- line_cnt: 0.
- err: 0.
- Byte phase, edge registers and held R: 0.
REQ-037 After rstn release, no write shall occur before the first frame-start event, so a partial frame is never captured.

Structure
REQ-038 Shared package cam_pkg shall hold H_ACTIVE, V_ACTIVE, FRAME_PIXELS, the FSM state encoding and the err bit indices.
REQ-039 Byte pairing and RGB444 packing (REQ-026, REQ-027, err[0]) shall be one sub-module, cam_byte_pack; FSM, counters and flags stay in cam_capture.

Verification
REQ-040 Continuous mode, two frames of 480 lines × 1280 bytes:
- 307200 pix_we pulses per frame.
- Last pix_addr 307199.
- frame_done pulses twice.
- err=000.
REQ-041 Byte pair 0x0A,0x5C -> pix_data=0xC5A, one cycle after the second byte.
REQ-042 Single-shot with snap_req pulsed once, three frames driven:
- Exactly one frame is written.
- State ends in HOLD with busy=0.
- A second snap_req captures exactly one more frame.
REQ-043 Line 7 driven with 1279 bytes:
- err[0] and err[1] set.
- err[2] set at frame-end.
- clr_err returns err to 000.
REQ-044 cap_en dropped at pix_addr=1000, mid-line:
- pix_we=0 from the next cycle.
- No frame_done pulse.
- cap_en raised again -> next frame starts at pix_addr 0.
REQ-045 rstn asserted mid-frame with no clock edge -> all outputs at their reset values immediately; after release, frame-start at 0 and no writes during the remainder of the interrupted frame.
